// File: rtl/video_rx_timing.sv
// Receive-side video timing recovery: turns an HS/VS/DE/RGB bus into a qualified pixel
// stream with coordinates and frame markers, and measures and locks onto the input format.
module video_rx_timing #(
  parameter int DATA_W      = 16,
  parameter int POS_W       = 11,
  parameter int LOCK_FRAMES = 2
) (
  input  logic              pixel_clk,
  input  logic              sys_rst,
  input  logic              video_hs,
  input  logic              video_vs,
  input  logic              video_de,
  input  logic [DATA_W-1:0] video_rgb,
  output logic              pix_valid,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic [POS_W-1:0]  pix_xpos,
  output logic [POS_W-1:0]  pix_ypos,
  output logic [POS_W-1:0]  h_disp,
  output logic [POS_W-1:0]  v_disp,
  output logic [11:0]       h_total,
  output logic [10:0]       v_total,
  output logic              locked,
  output logic              fmt_err
);

  typedef struct packed {
    logic [POS_W-1:0] h_disp;
    logic [POS_W-1:0] v_disp;
    logic [11:0]      h_total;
    logic [10:0]      v_total;
  } fmt_t;

  localparam logic [POS_W-1:0] POS_MAX  = '1;
  localparam logic [11:0]      HCNT_MAX = '1;
  localparam logic [10:0]      VCNT_MAX = '1;
  localparam logic [3:0]       LOCK_N   = 4'(LOCK_FRAMES);

  // Stage 1 and its delayed copy (edge detection)
  logic              hs_q, vs_q, de_q;
  logic [DATA_W-1:0] rgb_q;
  logic              hs_prev_q, vs_prev_q, de_prev_q;

  // Measurement state
  logic [POS_W-1:0] x_q, x_d, y_q, y_d, ref_w_q, ref_w_d;
  logic [11:0]      hcnt_q, hcnt_d, ref_h_q, ref_h_d;
  logic [10:0]      vcnt_q, vcnt_d;
  logic             ref_h_vld_q, ref_h_vld_d, bad_q, bad_d;
  logic             frame_seen_q, frame_seen_d, sof_pend_q, sof_pend_d;
  logic [3:0]       match_q, match_d;
  fmt_t             fmt_q, fmt_d;
  logic             locked_q, locked_d, fmt_err_q, fmt_err_d;

  // Output stage
  logic              pix_valid_q, pix_valid_d, pix_sof_q, pix_sof_d, pix_eol_q, pix_eol_d;
  logic [DATA_W-1:0] pix_data_q, pix_data_d;
  logic [POS_W-1:0]  pix_xpos_q, pix_xpos_d, pix_ypos_q, pix_ypos_d;

  logic             vs_fall, hs_fall, de_fall;
  logic             first_run, w_bad, h_bad, frame_bad, valid_now;
  logic [POS_W-1:0] y_close, ref_w_close;
  logic [11:0]      ref_h_close;
  logic [10:0]      vcnt_close;
  fmt_t             meas;

  assign vs_fall = vs_prev_q & ~vs_q;
  assign hs_fall = hs_prev_q & ~hs_q;
  assign de_fall = de_prev_q & ~de_q;

  // "Closing" views fold in a run or line that ends in this very cycle, so a VS fall
  // coinciding with an HS or DE fall still counts the last line of the old frame.
  assign first_run   = (y_q == '0);
  assign y_close     = (de_fall && y_q != POS_MAX) ? y_q + POS_W'(1) : y_q;
  assign ref_w_close = (de_fall && first_run) ? x_q : ref_w_q;
  assign w_bad       = de_fall && !first_run && (x_q != ref_w_q);
  assign ref_h_close = (hs_fall && !ref_h_vld_q) ? hcnt_q : ref_h_q;
  assign h_bad       = hs_fall && ref_h_vld_q && (hcnt_q != ref_h_q);
  assign vcnt_close  = (hs_fall && vcnt_q != VCNT_MAX) ? vcnt_q + 11'd1 : vcnt_q;
  assign frame_bad   = bad_q | w_bad | h_bad;
  assign meas        = {ref_w_close, y_close, ref_h_close, vcnt_close};
  assign valid_now   = de_q & (frame_seen_q | vs_fall);

  always_comb begin
    // NOTE: every _d takes its hold/default value first, so no path through this block can infer a latch.
    x_d          = '0;
    hcnt_d       = hs_fall ? 12'd1 : ((hcnt_q == HCNT_MAX) ? hcnt_q : hcnt_q + 12'd1);
    y_d          = y_close;
    ref_w_d      = ref_w_close;
    ref_h_d      = ref_h_close;
    ref_h_vld_d  = ref_h_vld_q | hs_fall;
    vcnt_d       = vcnt_close;
    bad_d        = frame_bad;
    frame_seen_d = frame_seen_q | vs_fall;
    sof_pend_d   = (sof_pend_q | vs_fall) & ~valid_now;
    match_d      = match_q;
    locked_d     = locked_q;
    fmt_d        = fmt_q;
    fmt_err_d    = 1'b0;

    if (de_q) x_d = (x_q == POS_MAX) ? x_q : x_q + POS_W'(1);

    if (vs_fall) begin
      y_d         = '0;
      vcnt_d      = '0;
      ref_h_vld_d = 1'b0;
      bad_d       = 1'b0;
      if (frame_seen_q) begin
        if (frame_bad || y_close == '0) begin
          match_d   = '0;
          locked_d  = 1'b0;
          fmt_err_d = locked_q;
        end else if (meas == fmt_q) begin
          if (match_q < LOCK_N) match_d = match_q + 4'd1;
          locked_d = (match_d == LOCK_N);
        end else begin
          fmt_d     = meas;
          match_d   = '0;
          locked_d  = 1'b0;
          fmt_err_d = locked_q;
        end
      end
    end

    pix_valid_d = valid_now;
    pix_data_d  = rgb_q;
    pix_sof_d   = valid_now & (sof_pend_q | vs_fall);
    pix_eol_d   = valid_now & ~video_de;
    pix_xpos_d  = x_q;
    pix_ypos_d  = vs_fall ? '0 : y_q;
  end

  always_ff @(posedge pixel_clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    if (sys_rst) begin
      hs_q         <= 1'b0;
      vs_q         <= 1'b0;
      de_q         <= 1'b0;
      rgb_q        <= '0;
      hs_prev_q    <= 1'b0;
      vs_prev_q    <= 1'b0;
      de_prev_q    <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      ref_w_q      <= '0;
      hcnt_q       <= '0;
      ref_h_q      <= '0;
      ref_h_vld_q  <= 1'b0;
      vcnt_q       <= '0;
      bad_q        <= 1'b0;
      frame_seen_q <= 1'b0;
      sof_pend_q   <= 1'b0;
      match_q      <= '0;
      fmt_q        <= '0;
      locked_q     <= 1'b0;
      fmt_err_q    <= 1'b0;
      pix_valid_q  <= 1'b0;
      pix_data_q   <= '0;
      pix_sof_q    <= 1'b0;
      pix_eol_q    <= 1'b0;
      pix_xpos_q   <= '0;
      pix_ypos_q   <= '0;
    end else begin
      hs_q         <= video_hs;
      vs_q         <= video_vs;
      de_q         <= video_de;
      rgb_q        <= video_rgb;
      hs_prev_q    <= hs_q;
      vs_prev_q    <= vs_q;
      de_prev_q    <= de_q;
      x_q          <= x_d;
      y_q          <= y_d;
      ref_w_q      <= ref_w_d;
      hcnt_q       <= hcnt_d;
      ref_h_q      <= ref_h_d;
      ref_h_vld_q  <= ref_h_vld_d;
      vcnt_q       <= vcnt_d;
      bad_q        <= bad_d;
      frame_seen_q <= frame_seen_d;
      sof_pend_q   <= sof_pend_d;
      match_q      <= match_d;
      fmt_q        <= fmt_d;
      locked_q     <= locked_d;
      fmt_err_q    <= fmt_err_d;
      pix_valid_q  <= pix_valid_d;
      pix_data_q   <= pix_data_d;
      pix_sof_q    <= pix_sof_d;
      pix_eol_q    <= pix_eol_d;
      pix_xpos_q   <= pix_xpos_d;
      pix_ypos_q   <= pix_ypos_d;
    end
  end

  assign pix_valid = pix_valid_q;
  assign pix_data  = pix_data_q;
  assign pix_sof   = pix_sof_q;
  assign pix_eol   = pix_eol_q;
  assign pix_xpos  = pix_xpos_q;
  assign pix_ypos  = pix_ypos_q;
  assign h_disp    = fmt_q.h_disp;
  assign v_disp    = fmt_q.v_disp;
  assign h_total   = fmt_q.h_total;
  assign v_total   = fmt_q.v_total;
  assign locked    = locked_q;
  assign fmt_err   = fmt_err_q;

endmodule
